// File: rtl/deadlock_mon_pkg.sv
// Shared definitions for the dataflow deadlock monitor: detector FSM states and
// default window/counter sizing.
package deadlock_mon_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SUSPECT = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [1:0] ST_RUN     = RUN;
  localparam logic [1:0] ST_SUSPECT = SUSPECT;
  localparam logic [1:0] ST_LOCKED  = LOCKED;

  localparam int DEFAULT_THRESHOLD = 16;
  localparam int DEFAULT_CNT_W     = 16;

endpackage

// File: rtl/stall_sat_counter.sv
// Saturating stall-window counter: clear, load-one, increment or hold, with
// the increment pinned at all-ones so a long stall never wraps.
module stall_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             load_one,
  input  logic             incr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      count <= '0;
    end else if (load_one) begin
      count <= CNT_W'(1);
    end else if (incr && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/deadlock_stall_detector.sv
// Declares a kernel deadlocked once every top-level process is idle or blocked,
// at least one is blocked, and no external stream is blocking, for THRESHOLD cycles.
module deadlock_stall_detector
  import deadlock_mon_pkg::*;
#(
  parameter int NUM_AXIS  = 2,
  parameter int NUM_IDLE  = 9,
  parameter int NUM_BLK   = 4,
  parameter int THRESHOLD = DEFAULT_THRESHOLD,
  parameter int CNT_W     = DEFAULT_CNT_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [NUM_IDLE-1:0] inst_idle_sigs,
  input  logic [NUM_BLK-1:0]  inst_block_sigs,
  output logic                block,
  output logic [NUM_BLK-1:0]  block_snapshot,
  output logic [CNT_W-1:0]    stall_cycles,
  output logic [1:0]          state_o
);

  logic [1:0] state;
  logic [1:0] state_next;
  logic       restart;
  logic       stalled_raw;
  logic       stalled;
  logic       sig_changed;
  logic       at_limit;
  logic       cnt_clr;
  logic       cnt_load;
  logic       cnt_inc;
  logic       snap_load;
  logic       lock_set;

  assign restart = reset | clear;

  // Sub-instance idles above NUM_BLK have no paired block signal and do not
  // participate in stall detection.
  generate
    if (NUM_IDLE > NUM_BLK) begin : g_idle_upper
      logic idle_upper_unused;
      assign idle_upper_unused = ^inst_idle_sigs[NUM_IDLE-1:NUM_BLK];
    end
  endgenerate

  assign stalled_raw = (&(inst_idle_sigs[NUM_BLK-1:0] | inst_block_sigs))
                     & (|inst_block_sigs)
                     & ~(|axis_block_sigs);

  // An unknown stalled term falls into the else path, so X inputs never count.
  always_comb begin
    stalled = 1'b0;
    if (stalled_raw) begin
      stalled = 1'b1;
    end
  end

  assign sig_changed = (inst_block_sigs != block_snapshot);
  assign at_limit    = (stall_cycles == CNT_W'(THRESHOLD - 1));

  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    cnt_load   = 1'b0;
    cnt_inc    = 1'b0;
    snap_load  = 1'b0;
    lock_set   = 1'b0;
    case (state)
      ST_RUN: begin
        if (stalled) begin
          state_next = ST_SUSPECT;
          snap_load  = 1'b1;
          cnt_load   = 1'b1;
        end else begin
          cnt_clr = 1'b1;
        end
      end
      ST_SUSPECT: begin
        if (!stalled) begin
          state_next = ST_RUN;
          cnt_clr    = 1'b1;
        end else if (sig_changed) begin
          snap_load = 1'b1;
          cnt_load  = 1'b1;
        end else if (at_limit) begin
          state_next = ST_LOCKED;
          lock_set   = 1'b1;
          cnt_inc    = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      // Once locked, only the stall counter keeps tracking; exit is by restart.
      ST_LOCKED: begin
        cnt_inc = stalled;
      end
      default: begin
        state_next = ST_RUN;
        cnt_clr    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (restart) begin
      state          <= ST_RUN;
      block          <= 1'b0;
      block_snapshot <= '0;
    end else begin
      state <= state_next;
      if (lock_set) begin
        block <= 1'b1;
      end
      if (snap_load) begin
        block_snapshot <= inst_block_sigs;
      end
    end
  end

  stall_sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clock   (clock),
    .reset   (restart),
    .clr     (cnt_clr),
    .load_one(cnt_load),
    .incr    (cnt_inc),
    .count   (stall_cycles)
  );

  assign state_o = state;

endmodule
